// File: rtl/cdf_mem_pkg.sv
// cdf_mem_pkg: shared widths, FSM state and controller reset addresses for the cdf memory interface.
package cdf_mem_pkg;
  localparam int CDF_DW = 128;
  localparam int CDF_AW = 16;
  localparam int CDF_RESET_ADDR0 = 400;
  localparam int CDF_RESET_ADDR1 = 401;
  typedef enum logic {S_CLEAR, S_READY} cdf_mem_state_t;
endpackage

// File: rtl/cdf_sram_responder_if.sv
// cdf_sram_responder_if: controller-to-memory bus, one write port and two read ports.
interface cdf_sram_responder_if
  import cdf_mem_pkg::*;
#(
  parameter int DW = CDF_DW,
  parameter int AW = CDF_AW
);
  logic WE;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteBus;
  logic [AW-1:0] ReadAddress1;
  logic [AW-1:0] ReadAddress2;
  logic [DW-1:0] ReadBus1;
  logic [DW-1:0] ReadBus2;
  logic Ready;
  logic AddrErr;
  modport master (
    output WE, WriteAddress, WriteBus, ReadAddress1, ReadAddress2,
    input ReadBus1, ReadBus2, Ready, AddrErr
  );
  modport slave (
    input WE, WriteAddress, WriteBus, ReadAddress1, ReadAddress2,
    output ReadBus1, ReadBus2, Ready, AddrErr
  );
endinterface

// File: rtl/cdf_sram_array.sv
// cdf_sram_array: plain storage with one synchronous write port and two synchronous read ports.
module cdf_sram_array #(
  parameter int DW = 128,
  parameter int DEPTH = 1024,
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          writeEn,
  input  logic [PW-1:0] writeAddr,
  input  logic [DW-1:0] writeData,
  input  logic [PW-1:0] readAddr1,
  input  logic [PW-1:0] readAddr2,
  output logic [DW-1:0] readData1,
  output logic [DW-1:0] readData2
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (writeEn) mem[writeAddr] <= writeData;
    readData1 <= mem[readAddr1];
    readData2 <= mem[readAddr2];
  end
endmodule

// File: rtl/cdf_sram_responder.sv
// cdf_sram_responder: self-clearing dual-read memory responder with write-first forwarding and range flagging.
module cdf_sram_responder
  import cdf_mem_pkg::*;
#(
  parameter int DW = CDF_DW,
  parameter int AW = CDF_AW,
  parameter int DEPTH = 1024
) (
  input logic clk,
  input logic reset,
  cdf_sram_responder_if.slave bus
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  cdf_mem_state_t state;
  logic [PW-1:0] clrPtr;
  logic fwd1, fwd2, hit1, hit2;
  logic [DW-1:0] fwdData, rd1, rd2;
  logic in1, in2, inW, wrOk, clearing, memWe;
  logic [PW-1:0] memWa;
  logic [DW-1:0] memWd;
  always_comb begin
    in1 = {1'b0, bus.ReadAddress1} < LIMIT;
    in2 = {1'b0, bus.ReadAddress2} < LIMIT;
    inW = {1'b0, bus.WriteAddress} < LIMIT;
    clearing = state == S_CLEAR;
    wrOk = !clearing && bus.WE && inW;
    memWe = clearing || wrOk;
    memWa = clearing ? clrPtr : bus.WriteAddress[PW-1:0];
    memWd = clearing ? '0 : bus.WriteBus;
  end
  cdf_sram_array #(.DW(DW), .DEPTH(DEPTH), .PW(PW)) u_array (
    .clk(clk),
    .writeEn(memWe),
    .writeAddr(memWa),
    .writeData(memWd),
    .readAddr1(bus.ReadAddress1[PW-1:0]),
    .readAddr2(bus.ReadAddress2[PW-1:0]),
    .readData1(rd1),
    .readData2(rd2)
  );
  // The array reads old data on a colliding edge, so the written word is kept aside for forwarding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_CLEAR;
      clrPtr <= '0;
      bus.Ready <= 1'b0;
      bus.AddrErr <= 1'b0;
      fwd1 <= 1'b0;
      fwd2 <= 1'b0;
      hit1 <= 1'b0;
      hit2 <= 1'b0;
      fwdData <= '0;
    end else if (clearing) begin
      if (clrPtr == PW'(DEPTH - 1)) begin
        state <= S_READY;
        bus.Ready <= 1'b1;
      end else clrPtr <= clrPtr + 1'b1;
    end else begin
      fwd1 <= wrOk && bus.ReadAddress1 == bus.WriteAddress;
      fwd2 <= wrOk && bus.ReadAddress2 == bus.WriteAddress;
      hit1 <= in1;
      hit2 <= in2;
      if (wrOk) fwdData <= bus.WriteBus;
      bus.AddrErr <= !in1 || !in2 || (bus.WE && !inW);
    end
  end
  assign bus.ReadBus1 = fwd1 ? fwdData : hit1 ? rd1 : '0;
  assign bus.ReadBus2 = fwd2 ? fwdData : hit2 ? rd2 : '0;
endmodule

// File: tb/tb_cdf_sram_responder.sv
// tb_cdf_sram_responder: directed table-driven checks of clear sweep, reads, forwarding, range errors and reset.
module tb_cdf_sram_responder;
  typedef struct {
    logic we;
    logic [15:0] wa;
    logic [127:0] wd;
    logic [15:0] ra1;
    logic [15:0] ra2;
    logic [127:0] e1;
    logic [127:0] e2;
    logic eErr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[14];
  cdf_sram_responder_if #(.DW(128), .AW(16)) bus();
  cdf_sram_responder #(.DW(128), .AW(16), .DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [15:0] wa, input logic [127:0] wd, input logic [15:0] ra1, input logic [15:0] ra2);
    bus.WE = we;
    bus.WriteAddress = wa;
    bus.WriteBus = wd;
    bus.ReadAddress1 = ra1;
    bus.ReadAddress2 = ra2;
  endtask
  initial begin
    logic [127:0] d, c, a5, ff, e, p2, p9;
    d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000001;
    c = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    a5 = {16{8'hA5}};
    ff = '1;
    e = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    p2 = 128'h2222;
    p9 = 128'h9999_0000_0000_0000_0000_0000_0000_0009;
    vecs[0]  = '{1'b1, 16'd5,  d,  16'd0,     16'd0,  '0, '0, 1'b0};
    vecs[1]  = '{1'b0, 16'd0,  '0, 16'd5,     16'd5,  d,  d,  1'b0};
    vecs[2]  = '{1'b1, 16'd6,  c,  16'd5,     16'd6,  d,  c,  1'b0};
    vecs[3]  = '{1'b1, 16'd7,  a5, 16'd7,     16'd6,  a5, c,  1'b0};
    vecs[4]  = '{1'b0, 16'd0,  '0, 16'd7,     16'd5,  a5, d,  1'b0};
    vecs[5]  = '{1'b1, 16'd16, ff, 16'd400,   16'd15, '0, '0, 1'b1};
    vecs[6]  = '{1'b0, 16'd0,  '0, 16'd0,     16'd15, '0, '0, 1'b0};
    vecs[7]  = '{1'b0, 16'd0,  '0, 16'hFFFF,  16'd3,  '0, '0, 1'b1};
    vecs[8]  = '{1'b1, 16'd15, e,  16'd15,    16'd14, e,  '0, 1'b0};
    vecs[9]  = '{1'b1, 16'd20, ff, 16'd15,    16'd15, e,  e,  1'b1};
    vecs[10] = '{1'b0, 16'd20, ff, 16'd2,     16'd9,  '0, '0, 1'b0};
    vecs[11] = '{1'b1, 16'd2,  p2, 16'd0,     16'd0,  '0, '0, 1'b0};
    vecs[12] = '{1'b1, 16'd9,  p9, 16'd2,     16'd9,  p2, p9, 1'b0};
    vecs[13] = '{1'b0, 16'd0,  '0, 16'd9,     16'd2,  p9, p2, 1'b0};
    drive(1'b0, '0, '0, '0, '0);
    #1;
    chk("rst_rb1", bus.ReadBus1, '0);
    chk("rst_rb2", bus.ReadBus2, '0);
    chk("rst_ready", 128'(bus.Ready), 128'(1'b0));
    chk("rst_err", 128'(bus.AddrErr), 128'(1'b0));
    step();
    step();
    reset = 1'b0;
    bus.ReadAddress1 = 16'd400;
    for (int i = 0; i < 16; i++) begin
      drive(i < 10, 16'd3, 128'h11, 16'd400, 16'd3);
      step();
      chk($sformatf("clr_ready%0d", i), 128'(bus.Ready), 128'(i == 15));
      chk($sformatf("clr_rb1_%0d", i), bus.ReadBus1, '0);
      chk($sformatf("clr_err%0d", i), 128'(bus.AddrErr), 128'(1'b0));
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, '0, 16'(i), 16'(15 - i));
      step();
      chk($sformatf("zero_rb1_%0d", i), bus.ReadBus1, '0);
      chk($sformatf("zero_rb2_%0d", i), bus.ReadBus2, '0);
      chk($sformatf("zero_err%0d", i), 128'(bus.AddrErr), 128'(1'b0));
    end
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      step();
      chk($sformatf("vec%0d_rb1", i), bus.ReadBus1, vecs[i].e1);
      chk($sformatf("vec%0d_rb2", i), bus.ReadBus2, vecs[i].e2);
      chk($sformatf("vec%0d_err", i), 128'(bus.AddrErr), 128'(vecs[i].eErr));
    end
    drive(1'b0, '0, '0, 16'd2, 16'd9);
    #3 reset = 1'b1;
    #1;
    chk("mid_rb1", bus.ReadBus1, '0);
    chk("mid_rb2", bus.ReadBus2, '0);
    chk("mid_ready", 128'(bus.Ready), 128'(1'b0));
    #9 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("re_ready%0d", i), 128'(bus.Ready), 128'(i == 15));
    end
    drive(1'b0, '0, '0, 16'd2, 16'd9);
    step();
    chk("re_rb1_addr2", bus.ReadBus1, '0);
    chk("re_rb2_addr9", bus.ReadBus2, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
